// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants, state type and width helpers for the motion-estimation controller
package me_pkg;
    localparam int LOG_B    = 4;
    localparam int W        = 1 << LOG_B;
    localparam int DW       = 8;
    localparam int CNT_W    = 3 * LOG_B + 1;
    localparam int ADDR_R_W = 2 * LOG_B;
    localparam int ADDR_S_W = 2 * LOG_B + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int lb);
        return 3 * lb + 1;
    endfunction

    function automatic int addr_r_w(input int lb);
        return 2 * lb;
    endfunction

    function automatic int addr_s_w(input int lb);
        return 2 * lb + 1;
    endfunction
endpackage

// File: rtl/me_if.sv
// rtl/me_if.sv - memory/PE-array signal bundle of the motion-estimation controller
interface me_if #(
    parameter int LOG_B = me_pkg::LOG_B,
    parameter int DW    = me_pkg::DW
);
    import me_pkg::*;

    logic                          start;
    logic                          busy;
    logic                          done;
    logic [addr_r_w(LOG_B)-1:0]    AddressR;
    logic [addr_s_w(LOG_B)-1:0]    AddressS1;
    logic [addr_s_w(LOG_B)-1:0]    AddressS2;
    logic [(1 << LOG_B)-1:0]       S1S2mux;
    logic [(1 << LOG_B)-1:0]       NewDist;
    logic [(1 << LOG_B)*DW-1:0]    AccBus;
    logic [DW-1:0]                 BestDist;
    logic [LOG_B-1:0]              MotionX;
    logic [LOG_B-1:0]              MotionY;

    modport slave (
        input  start, AccBus,
        output busy, done, AddressR, AddressS1, AddressS2,
               S1S2mux, NewDist, BestDist, MotionX, MotionY
    );

    modport master (
        output start, AccBus,
        input  busy, done, AddressR, AddressS1, AddressS2,
               S1S2mux, NewDist, BestDist, MotionX, MotionY
    );
endinterface

// File: rtl/me_best_match.sv
// rtl/me_best_match.sv - running minimum of ready PE accumulators and its motion vector
module me_best_match #(
    parameter int LOG_B = me_pkg::LOG_B,
    parameter int DW    = me_pkg::DW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_valid,
    input  logic [LOG_B-1:0]            i_idx,
    input  logic [LOG_B-1:0]            i_vy,
    input  logic [(1 << LOG_B)*DW-1:0]  i_acc,
    output logic [DW-1:0]               o_best,
    output logic [LOG_B-1:0]            o_mx,
    output logic [LOG_B-1:0]            o_my
);
    import me_pkg::*;

    logic [DW-1:0]    r_best;
    logic [LOG_B-1:0] r_mx;
    logic [LOG_B-1:0] r_my;
    logic [DW-1:0]    w_val;

    assign w_val = i_acc[i_idx*DW +: DW];

    // Strict less-than: ties keep the earlier vector and a saturated all-ones
    // accumulator can never displace the all-ones start value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best <= '1;
            r_mx   <= '0;
            r_my   <= '0;
        end else if (i_clear) begin
            r_best <= '1;
            r_mx   <= '0;
            r_my   <= '0;
        end else if (i_valid && (w_val < r_best)) begin
            r_best <= w_val;
            r_mx   <= i_idx;
            r_my   <= i_vy;
        end
    end

    assign o_best = r_best;
    assign o_mx   = r_mx;
    assign o_my   = r_my;
endmodule

// File: rtl/me_controller.sv
// rtl/me_controller.sv - full-search block-match sequencer: run FSM, address/PE control decode, best-match tracking
module me_controller #(
    parameter int LOG_B = me_pkg::LOG_B,
    parameter int DW    = me_pkg::DW
) (
    input  logic clk,
    input  logic reset,
    me_if.slave  bus
);
    import me_pkg::*;

    localparam int NPE = 1 << LOG_B;
    localparam int CW  = cnt_w(LOG_B);
    localparam int QW  = CW - LOG_B;
    localparam int ASW = addr_s_w(LOG_B);
    localparam logic [CW-1:0] T_W2   = CW'(NPE * NPE);
    localparam logic [CW-1:0] T_W3   = CW'(NPE * NPE * NPE);
    localparam logic [CW-1:0] T_LAST = CW'(NPE * NPE * NPE + NPE - 1);

    state_t           r_state;
    logic [CW-1:0]    r_t;
    logic             r_busy;
    logic             r_done;

    logic             w_run;
    logic             w_clear;
    logic [LOG_B-1:0] w_cm;
    logic [QW-1:0]    w_q;
    logic [QW-1:0]    w_qm1;
    logic [NPE-1:0]   w_mux;
    logic [NPE-1:0]   w_newdist;
    logic [NPE-1:0]   w_ready;
    logic             w_rdy_any;
    logic [LOG_B-1:0] w_rdy_idx;
    logic [CW-1:0]    w_vd;
    logic [LOG_B-1:0] w_vy;

    // Search-window row of a folded count: (x div W) + (x mod W).
    function automatic logic [ASW-1:0] fold(input logic [QW-1:0] x);
        return ASW'(x[QW-1:LOG_B]) + ASW'(x[LOG_B-1:0]);
    endfunction

    assign w_run   = (r_state == RUN);
    assign w_clear = !w_run && bus.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_t     <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (r_t == T_LAST) begin
                        r_state <= DONE;
                        r_t     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_t <= r_t + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_t     <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign w_cm  = r_t[LOG_B-1:0];
    assign w_q   = r_t[CW-1:LOG_B];
    assign w_qm1 = w_q - QW'(1);

    // Top count bit set means t >= W^3: the reference block has been fully streamed.
    assign bus.AddressR  = (w_run && !r_t[CW-1]) ? r_t[2*LOG_B-1:0] : '0;
    assign bus.AddressS1 = w_run ? (fold(w_q) << LOG_B) + ASW'(w_cm) : '0;
    assign bus.AddressS2 = (w_run && (w_q != '0)) ? (fold(w_qm1) << LOG_B) + ASW'(w_cm) : '0;

    for (genvar gi = 0; gi < NPE; gi++) begin : g_pe
        logic [CW-1:0] w_d;
        logic          w_phase;
        assign w_d           = r_t - CW'(gi);
        assign w_phase       = w_run && (r_t >= CW'(gi)) && (w_d[2*LOG_B-1:0] == '0);
        assign w_mux[gi]     = w_run && (LOG_B'(gi) <= w_cm);
        assign w_newdist[gi] = w_phase && !w_d[CW-1];
        assign w_ready[gi]   = w_phase && (w_d >= T_W2) && (w_d <= T_W3);
    end

    assign bus.S1S2mux = w_mux;
    assign bus.NewDist = w_newdist;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    // PE readiness points are W^2 apart per PE and staggered by one cycle, so at most one bit is set.
    always_comb begin
        w_rdy_any = 1'b0;
        w_rdy_idx = '0;
        for (int i = 0; i < NPE; i++) begin
            if (w_ready[i]) begin
                w_rdy_any = 1'b1;
                w_rdy_idx = LOG_B'(i);
            end
        end
    end

    assign w_vd = r_t - CW'(w_rdy_idx);
    assign w_vy = LOG_B'((w_vd >> (2*LOG_B)) - CW'(1));

    me_best_match #(
        .LOG_B (LOG_B),
        .DW    (DW)
    ) u_best (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_valid (w_rdy_any),
        .i_idx   (w_rdy_idx),
        .i_vy    (w_vy),
        .i_acc   (bus.AccBus),
        .o_best  (bus.BestDist),
        .o_mx    (bus.MotionX),
        .o_my    (bus.MotionY)
    );
endmodule

// File: tb/tb_me_controller.sv
// tb/tb_me_controller.sv - randomized self-checking bench for me_controller against a pixel-level block-match model
module tb_me_controller;
    localparam int LB     = 2;
    localparam int W      = 4;
    localparam int W2     = 16;
    localparam int W3     = 64;
    localparam int RUNLEN = W3 + W;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    int          pix_r    [W][W];
    int          pix_s    [2*W-1][2*W-1];
    int          dist_tab [W][W];
    int          exp_best;
    int          exp_mx;
    int          exp_my;
    logic [21:0] obs_dec  [RUNLEN];

    me_if #(.LOG_B(LB), .DW(8)) bus ();

    me_controller #(.LOG_B(LB), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int fold(input int x);
        return x / W + x % W;
    endfunction

    function automatic logic [21:0] decode_model(input int t);
        int cm, q, ar, s1, s2;
        logic [3:0] mux, nd;
        cm = t % W;
        q  = t / W;
        ar = (t < W3) ? t % W2 : 0;
        s1 = fold(q) * W + cm;
        s2 = (q == 0) ? 0 : fold(q - 1) * W + cm;
        for (int i = 0; i < W; i++) begin
            mux[i] = (i <= cm);
            nd[i]  = (t >= i) && ((t - i) % W2 == 0) && (t - i < W3);
        end
        return {4'(ar), 5'(s1), 5'(s2), mux, nd};
    endfunction

    // Sum of absolute differences for every candidate vector, saturating like the PEs.
    function automatic void compute_dist();
        for (int vy = 0; vy < W; vy++) begin
            for (int vx = 0; vx < W; vx++) begin
                int s;
                s = 0;
                for (int y = 0; y < W; y++) begin
                    for (int x = 0; x < W; x++) begin
                        int d;
                        d = pix_r[y][x] - pix_s[y+vy][x+vx];
                        s += (d < 0) ? -d : d;
                    end
                end
                dist_tab[vy][vx] = (s > 255) ? 255 : s;
            end
        end
    endfunction

    function automatic void random_pixels(input int pmax);
        for (int y = 0; y < 2*W-1; y++)
            for (int x = 0; x < 2*W-1; x++)
                pix_s[y][x] = $urandom_range(0, pmax);
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                pix_r[y][x] = $urandom_range(0, pmax);
        compute_dist();
    endfunction

    // Best vector over all candidates whose ready cycle precedes t_lim, earliest wins ties.
    function automatic void model_best(input int t_lim);
        exp_best = 255;
        exp_mx   = 0;
        exp_my   = 0;
        for (int vy = 0; vy < W; vy++) begin
            for (int vx = 0; vx < W; vx++) begin
                if ((vx + W2 * (vy + 1) < t_lim) && (dist_tab[vy][vx] < exp_best)) begin
                    exp_best = dist_tab[vy][vx];
                    exp_mx   = vx;
                    exp_my   = vy;
                end
            end
        end
    endfunction

    task automatic begin_run();
        bus.start = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input int t, input bit pulse);
        logic [21:0] got, want;
        logic [31:0] acc;
        got  = {bus.AddressR, bus.AddressS1, bus.AddressS2, bus.S1S2mux, bus.NewDist};
        want = decode_model(t);
        obs_dec[t] = got;
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL run_flags t=%0d busy=%b done=%b expected busy=1 done=0", t, bus.busy, bus.done);
        end
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL decode t=%0d got=%h expected=%h", t, got, want);
        end
        if (t == 0) begin
            total++;
            if ({bus.BestDist, bus.MotionX, bus.MotionY} !== {8'hFF, 2'd0, 2'd0}) begin
                bad++;
                $display("FAIL entry_clear best=%h mx=%0d my=%0d expected ff 0 0",
                         bus.BestDist, bus.MotionX, bus.MotionY);
            end
        end
        for (int i = 0; i < W; i++) begin
            int d;
            d = t - i;
            if (d >= W2 && d <= W3 && d % W2 == 0)
                acc[i*8 +: 8] = 8'(dist_tab[d / W2 - 1][i]);
            else
                acc[i*8 +: 8] = 8'($urandom_range(0, 2));
        end
        bus.AccBus = acc;
        bus.start  = pulse;
        @(negedge clk);
    endtask

    task automatic check_done(input string tag);
        logic [21:0] got;
        got = {bus.AddressR, bus.AddressS1, bus.AddressS2, bus.S1S2mux, bus.NewDist};
        model_best(RUNLEN);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_flags busy=%b done=%b expected busy=0 done=1", tag, bus.busy, bus.done);
        end
        total++;
        if (got !== 22'd0) begin
            bad++;
            $display("FAIL %s done_outputs got=%h expected=0", tag, got);
        end
        total++;
        if (bus.BestDist !== 8'(exp_best)) begin
            bad++;
            $display("FAIL %s best got=%0d expected=%0d", tag, bus.BestDist, exp_best);
        end
        total++;
        if ({bus.MotionX, bus.MotionY} !== {2'(exp_mx), 2'(exp_my)}) begin
            bad++;
            $display("FAIL %s vector got=(%0d,%0d) expected=(%0d,%0d)", tag,
                     bus.MotionX, bus.MotionY, exp_mx, exp_my);
        end
    endtask

    task automatic full_run(input string tag, input int pulse_t);
        begin_run();
        for (int t = 0; t < RUNLEN; t++)
            step(t, t == pulse_t);
        check_done(tag);
    endtask

    task automatic check_known(input string tag, input logic [7:0] best, input logic [1:0] mx, input logic [1:0] my);
        total++;
        if ({bus.BestDist, bus.MotionX, bus.MotionY} !== {best, mx, my}) begin
            bad++;
            $display("FAIL %s known best=%h mx=%0d my=%0d expected %h %0d %0d", tag,
                     bus.BestDist, bus.MotionX, bus.MotionY, best, mx, my);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.AccBus = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        total++;
        if ({bus.BestDist, bus.MotionX, bus.MotionY} !== {8'hFF, 2'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_result best=%h mx=%0d my=%0d expected ff 0 0",
                     bus.BestDist, bus.MotionX, bus.MotionY);
        end
        total++;
        if ({bus.AddressR, bus.AddressS1, bus.AddressS2, bus.S1S2mux, bus.NewDist} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {bus.AddressR, bus.AddressS1, bus.AddressS2, bus.S1S2mux, bus.NewDist});
        end
    endtask

    task automatic test_random_search();
        for (int k = 0; k < 3; k++) begin
            random_pixels(31);
            full_run("random", -1);
        end
    endtask

    task automatic test_decode_points();
        logic [21:0] want5;
        want5 = {4'd5, 5'd5, 5'd1, 4'b0011, 4'b0000};
        total++;
        if (obs_dec[5] !== want5) begin
            bad++;
            $display("FAIL decode_t5 got=%h expected=%h", obs_dec[5], want5);
        end
        total++;
        if (obs_dec[16][3:0] !== 4'b0001) begin
            bad++;
            $display("FAIL newdist_t16 got=%b expected=0001", obs_dec[16][3:0]);
        end
    endtask

    task automatic test_offset_match();
        random_pixels(255);
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                pix_r[y][x] = pix_s[y+1][x+2];
        compute_dist();
        full_run("offset", -1);
        check_known("offset", 8'h00, 2'd2, 2'd1);
    endtask

    task automatic test_tie();
        for (int vy = 0; vy < W; vy++)
            for (int vx = 0; vx < W; vx++)
                dist_tab[vy][vx] = $urandom_range(4, 254);
        dist_tab[0][1] = 3;
        dist_tab[2][3] = 3;
        full_run("tie", -1);
        check_known("tie", 8'd3, 2'd1, 2'd0);
    endtask

    task automatic test_saturated();
        for (int y = 0; y < 2*W-1; y++)
            for (int x = 0; x < 2*W-1; x++)
                pix_s[y][x] = 255;
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                pix_r[y][x] = 0;
        compute_dist();
        full_run("saturated", -1);
        check_known("saturated", 8'hFF, 2'd0, 2'd0);
    endtask

    task automatic test_start_ignored();
        random_pixels(31);
        full_run("start_in_run", 10);
    endtask

    task automatic test_restart();
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL restart_pre done=%b expected=1", bus.done);
        end
        random_pixels(31);
        full_run("restart", -1);
    endtask

    task automatic test_reset_midrun();
        random_pixels(31);
        begin_run();
        for (int t = 0; t < 30; t++)
            step(t, 1'b0);
        model_best(30);
        total++;
        if ({bus.BestDist, bus.MotionX, bus.MotionY} !== {8'(exp_best), 2'(exp_mx), 2'(exp_my)}) begin
            bad++;
            $display("FAIL partial_best got=%h/%0d/%0d expected=%0d/%0d/%0d",
                     bus.BestDist, bus.MotionX, bus.MotionY, exp_best, exp_mx, exp_my);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL midrun_flags busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        total++;
        if ({bus.BestDist, bus.MotionX, bus.MotionY} !== {8'hFF, 2'd0, 2'd0}) begin
            bad++;
            $display("FAIL midrun_result best=%h mx=%0d my=%0d expected ff 0 0",
                     bus.BestDist, bus.MotionX, bus.MotionY);
        end
        total++;
        if ({bus.AddressR, bus.AddressS1, bus.AddressS2, bus.S1S2mux, bus.NewDist} !== 22'd0) begin
            bad++;
            $display("FAIL midrun_outputs got=%h expected=0",
                     {bus.AddressR, bus.AddressS1, bus.AddressS2, bus.S1S2mux, bus.NewDist});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_random_search();
        test_decode_points();
        test_offset_match();
        test_tie();
        test_saturated();
        test_start_ignored();
        test_restart();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
